// File: rtl/game_timing_pkg.sv
// Shared timing constants and sequencer state encoding for the game tick path.
package game_timing_pkg;

  localparam int TIME_W = 28;

  localparam logic [TIME_W-1:0] LEVEL0_INTERVAL = 28'd12_499_999;
  localparam logic [TIME_W-1:0] LEVEL1_INTERVAL = 28'd9_999_999;
  localparam logic [TIME_W-1:0] LEVEL2_INTERVAL = 28'd7_142_856;
  localparam logic [TIME_W-1:0] LEVEL3_INTERVAL = 28'd4_999_999;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_REQ  = 3'd1,
    MOVE_WAIT = 3'd2,
    DRAW_REQ  = 3'd3,
    DRAW_WAIT = 3'd4
  } sched_state_e;

  function automatic logic [TIME_W-1:0] interval_for_level(input logic [1:0] lvl);
    case (lvl)
      2'd0:    return LEVEL0_INTERVAL;
      2'd1:    return LEVEL1_INTERVAL;
      2'd2:    return LEVEL2_INTERVAL;
      2'd3:    return LEVEL3_INTERVAL;
      default: return LEVEL0_INTERVAL;
    endcase
  endfunction

endpackage

// File: rtl/tick_detect.sv
// Drives the interval counter (interval, enable, clear) and turns its wrap point
// into a single-cycle game tick.
module tick_detect
  import game_timing_pkg::*;
(
  input  logic              clock_50,
  input  logic              resetn,
  input  logic [1:0]        level,
  input  logic              pause,
  input  logic [TIME_W-1:0] cur_time,
  output logic [TIME_W-1:0] counter_interval,
  output logic              counter_en,
  output logic              counter_reset,
  output logic              tick
);

  logic [1:0]        level_q;
  logic [1:0]        level_prev_q;
  logic [TIME_W-1:0] interval_q;
  logic              creset_q;
  logic              pause_q;
  logic              rstn_q;

  // The clear pulse lands one cycle after the new interval is loaded, so the
  // counter restarts against the new terminal value.
  always_ff @(posedge clock_50) begin
    if (!resetn) begin
      level_q      <= 2'd0;
      level_prev_q <= 2'd0;
      interval_q   <= interval_for_level(2'd0);
      creset_q     <= 1'b1;
      pause_q      <= 1'b0;
      rstn_q       <= 1'b0;
    end else begin
      level_q      <= level;
      level_prev_q <= level_q;
      interval_q   <= interval_for_level(level);
      creset_q     <= (level_q != level_prev_q);
      pause_q      <= pause;
      rstn_q       <= 1'b1;
    end
  end

  assign counter_interval = interval_q;
  assign counter_reset    = creset_q;
  assign counter_en       = ~pause_q & rstn_q;
  assign tick             = counter_en & ~creset_q & (cur_time == interval_q);

endmodule

// File: rtl/move_scheduler.sv
// Per-tick sequencer: one move request per agent (Pacman first) over req/ack,
// then a redraw request; ticks arriving mid-sequence are counted as overruns.
module move_scheduler
  import game_timing_pkg::*;
#(
  parameter int NUM_AGENTS = 5,
  parameter int TICK_CNT_W = 16
) (
  input  logic                  clock_50,
  input  logic                  resetn,
  input  logic [1:0]            level,
  input  logic                  pause,
  input  logic [TIME_W-1:0]     cur_time,
  output logic [TIME_W-1:0]     counter_interval,
  output logic                  counter_en,
  output logic                  counter_reset,
  output logic [NUM_AGENTS-1:0] move_req,
  input  logic [NUM_AGENTS-1:0] move_ack,
  output logic                  draw_req,
  input  logic                  draw_ack,
  output logic                  busy,
  output logic [TICK_CNT_W-1:0] tick_count,
  output logic                  overrun,
  input  logic                  clear_overrun
);

  localparam int IDX_W = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_AGENTS - 1);

  sched_state_e          state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      idx_d;
  logic [NUM_AGENTS-1:0] move_req_q;
  logic                  draw_req_q;
  logic                  busy_q;
  logic [TICK_CNT_W-1:0] tick_count_q;
  logic [TICK_CNT_W-1:0] tick_count_d;
  logic                  overrun_q;
  logic                  tick;

  tick_detect u_tick_detect (
    .clock_50         (clock_50),
    .resetn           (resetn),
    .level            (level),
    .pause            (pause),
    .cur_time         (cur_time),
    .counter_interval (counter_interval),
    .counter_en       (counter_en),
    .counter_reset    (counter_reset),
    .tick             (tick)
  );

  assign idx_d        = idx_q + IDX_W'(1);
  assign tick_count_d = tick_count_q + TICK_CNT_W'(1);

  // Sequencing FSM; every request passes through a REQ state so a dropped
  // request always stays low for one cycle before the next one rises.
  always_ff @(posedge clock_50) begin
    if (!resetn) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      move_req_q   <= '0;
      draw_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      tick_count_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      if (tick && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end else if (clear_overrun) begin
        overrun_q <= 1'b0;
      end else begin
        overrun_q <= overrun_q;
      end

      case (state_q)
        IDLE: begin
          if (tick) begin
            idx_q        <= '0;
            busy_q       <= 1'b1;
            tick_count_q <= tick_count_d;
            state_q      <= MOVE_REQ;
          end
        end
        MOVE_REQ: begin
          move_req_q <= NUM_AGENTS'(1) << idx_q;
          state_q    <= MOVE_WAIT;
        end
        MOVE_WAIT: begin
          if (move_ack[idx_q]) begin
            move_req_q <= '0;
            if (idx_q == LAST_IDX) begin
              state_q <= DRAW_REQ;
            end else begin
              idx_q   <= idx_d;
              state_q <= MOVE_REQ;
            end
          end
        end
        DRAW_REQ: begin
          draw_req_q <= 1'b1;
          state_q    <= DRAW_WAIT;
        end
        DRAW_WAIT: begin
          if (draw_ack) begin
            draw_req_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          move_req_q <= '0;
          draw_req_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign move_req   = move_req_q;
  assign draw_req   = draw_req_q;
  assign busy       = busy_q;
  assign tick_count = tick_count_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: level/interval table plus hand-written
// tick sequences covering handshakes, overrun, pause and reset abort.
module tb_move_scheduler;

  localparam int N = 5;
  localparam logic [27:0] INT0 = 28'd12_499_999;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  level = 2'd0;
  logic        pause = 1'b0;
  logic [27:0] cur_time = 28'd0;
  logic [27:0] counter_interval;
  logic        counter_en;
  logic        counter_reset;
  logic [N-1:0] move_req;
  logic [N-1:0] move_ack = '0;
  logic        draw_req;
  logic        draw_ack = 1'b0;
  logic        busy;
  logic [15:0] tick_count;
  logic        overrun;
  logic        clear_overrun = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  level;
    logic [27:0] exp_interval;
    logic        exp_pulse;
  } lvl_vec_t;

  lvl_vec_t vecs [6];

  move_scheduler #(.NUM_AGENTS(N), .TICK_CNT_W(16)) dut (
    .clock_50         (clk),
    .resetn           (resetn),
    .level            (level),
    .pause            (pause),
    .cur_time         (cur_time),
    .counter_interval (counter_interval),
    .counter_en       (counter_en),
    .counter_reset    (counter_reset),
    .move_req         (move_req),
    .move_ack         (move_ack),
    .draw_req         (draw_req),
    .draw_ack         (draw_ack),
    .busy             (busy),
    .tick_count       (tick_count),
    .overrun          (overrun),
    .clear_overrun    (clear_overrun)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One full tick sequence; optional overrun tick, tick+clear, pause, early ack, abort.
  task automatic run_seq(input int exp_count, input int inj_agent, input int injclr_agent,
                         input int pause_agent, input bit early_ack0, input bit abort_draw);
    logic [N-1:0] oh;
    cur_time = INT0;
    step();
    cur_time = 28'd0;
    check("tick_busy", busy, 1);
    check("tick_count_inc", tick_count, exp_count);
    check("tick_no_req_yet", move_req, 0);
    if (early_ack0) move_ack[0] = 1'b1;
    step();
    for (int i = 0; i < N; i++) begin
      oh = 5'b00001 << i;
      check("move_req_onehot", move_req, oh);
      if (i == 0 && early_ack0) begin
        step();
        move_ack[0] = 1'b0;
        check("early_ack_drop", move_req, 0);
      end else begin
        if (i == inj_agent) cur_time = INT0;
        if (i == injclr_agent) begin
          cur_time = INT0;
          clear_overrun = 1'b1;
        end
        if (i == pause_agent) pause = 1'b1;
        step();
        cur_time = 28'd0;
        clear_overrun = 1'b0;
        if (i == inj_agent || i == injclr_agent) begin
          check("overrun_set", overrun, 1);
          check("overrun_count_hold", tick_count, exp_count);
        end
        if (i == pause_agent) check("pause_en_low", counter_en, 0);
        check("move_req_hold1", move_req, oh);
        step();
        check("move_req_hold2", move_req, oh);
        step();
        check("move_req_hold3", move_req, oh);
        move_ack[i] = 1'b1;
        step();
        move_ack[i] = 1'b0;
        check("move_req_gap", move_req, 0);
        check("busy_mid", busy, 1);
      end
      step();
    end
    check("draw_req_rise", draw_req, 1);
    check("draw_no_move", move_req, 0);
    if (abort_draw) begin
      resetn = 1'b0;
      step();
      check("abort_draw_req", draw_req, 0);
      check("abort_busy", busy, 0);
      check("abort_tick_count", tick_count, 0);
      check("abort_creset", counter_reset, 1);
      check("abort_en", counter_en, 0);
      resetn = 1'b1;
      step();
      check("abort_release_creset", counter_reset, 0);
      check("abort_release_en", counter_en, 1);
    end else begin
      step();
      check("draw_req_hold", draw_req, 1);
      step();
      draw_ack = 1'b1;
      step();
      draw_ack = 1'b0;
      check("draw_req_drop", draw_req, 0);
      check("busy_done", busy, 0);
      check("tick_count_done", tick_count, exp_count);
    end
    if (pause_agent >= 0) begin
      pause = 1'b0;
      step();
      check("unpause_en", counter_en, 1);
    end
  endtask

  initial begin
    vecs[0] = '{2'd3, 28'd4_999_999,  1'b1};
    vecs[1] = '{2'd3, 28'd4_999_999,  1'b0};
    vecs[2] = '{2'd1, 28'd9_999_999,  1'b1};
    vecs[3] = '{2'd2, 28'd7_142_856,  1'b1};
    vecs[4] = '{2'd0, 28'd12_499_999, 1'b1};
    vecs[5] = '{2'd3, 28'd4_999_999,  1'b1};

    repeat (2) step();
    check("rst_interval", counter_interval, INT0);
    check("rst_creset", counter_reset, 1);
    check("rst_en", counter_en, 0);
    check("rst_move_req", move_req, 0);
    check("rst_draw_req", draw_req, 0);
    check("rst_busy", busy, 0);
    check("rst_tick_count", tick_count, 0);
    check("rst_overrun", overrun, 0);
    resetn = 1'b1;
    step();
    check("release_en", counter_en, 1);
    check("release_creset", counter_reset, 0);

    for (int v = 0; v < 6; v++) begin
      level = vecs[v].level;
      step();
      check("lvl_interval", counter_interval, vecs[v].exp_interval);
      check("lvl_creset_load", counter_reset, 0);
      step();
      check("lvl_creset_pulse", counter_reset, vecs[v].exp_pulse);
      step();
      check("lvl_creset_end", counter_reset, 0);
    end

    // Level 3 active: the level-0 terminal value must not tick.
    cur_time = INT0;
    step();
    cur_time = 28'd0;
    check("stale_interval_no_tick", busy, 0);
    level = 2'd0;
    repeat (3) step();
    check("back_to_lvl0", counter_interval, INT0);

    run_seq(1, 2, 3, -1, 1'b0, 1'b0);
    check("overrun_sticky", overrun, 1);
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    check("overrun_clear", overrun, 0);

    pause = 1'b1;
    step();
    check("pause_en", counter_en, 0);
    cur_time = INT0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("pause_no_tick", busy, 0);
    end
    cur_time = 28'd0;
    pause = 1'b0;
    step();
    check("pause_release_en", counter_en, 1);
    check("pause_count", tick_count, 1);

    run_seq(2, -1, -1, 1, 1'b0, 1'b0);
    check("pause_seq_no_overrun", overrun, 0);

    run_seq(3, -1, -1, -1, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
